fsm_stream_alu: RTL
===================

Name: fsm_stream_alu

Overview:
- Parametrised, opcode-driven successor to the course FSM datapath.
- Loads two N-bit operands as N_width-bit beats, LSB beat first, using a valid/ready handshake.
- Runs a host-supplied sequence of up to MAX_OPS operations from an 8-function library. Each operation updates an N-bit accumulator.
- Streams the accumulator back in N_width-bit beats under out_valid/out_ready backpressure.
- Sits between the TinyTapeout pin wrapper and the I/O pins; replaces the fixed op_val transition graph with explicit opcodes.

Parameters:
N, 64, operand/accumulator width; N must be even and a multiple of N_width.
N_width, 4, beat width; BEATS = N/N_width must be a power of 2 and at least 2.
MAX_OPS, 16, maximum operations per job; at least 1.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  begin a job; sampled in IDLE only.
abort  in  1  synchronous abort; returns to IDLE from any state.
in_valid  in  1  a/b beat valid.
in_ready  out  1  high in LOAD.
a  in  N_width  operand A beat.
b  in  N_width  operand B beat.
op_valid  in  1  opcode valid.
op_ready  out  1  high in EXEC.
op_code  in  3  function select, 0-7.
op_last  in  1  marks the final opcode of the job.
out  out  N_width  result beat; 0 when out_valid=0.
out_valid  out  1  high in DRAIN.
out_ready  in  1  sink accepts beat.
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse when the job completes.
err  out  1  sticky op-overflow flag.
state_res  out  2  IDLE=0, LOAD=1, EXEC=2, DRAIN=3.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE; a_reg, b_reg, acc, beat_cnt, op_cnt = 0.
  - All outputs 0: in_ready, op_ready, out_valid, busy, done, err, out, state_res.
  - Reset mid-job discards everything; no partial output.
- Handshakes: a transfer occurs only on a cycle where valid and ready are both high. All registers update on the clk rising edge.
- IDLE:
  - On start=1: a_reg, b_reg, acc, beat_cnt, op_cnt cleared; err cleared; go to LOAD.
  - start in any other state is ignored.
- LOAD:
  - Each in_valid beat writes a_reg[beat_cnt*N_width +: N_width]=a and the same slice of b_reg=b, then beat_cnt++.
  - The beat accepted with beat_cnt=BEATS-1 resets beat_cnt to 0 and moves to EXEC.
  - in_valid=0 holds state and counters.
- EXEC: each accepted opcode sets acc <= f(op_code, a_reg, b_reg, acc), with c=acc. All arithmetic is mod 2^N.
  - 0: (a&b)|c
  - 1: (a^b)+c
  - 2: |a-b| ^ c
  - 3: {c[N-1:N/2], min(a,b)[N/2-1:0]}
  - 4: max(a,b) + (c<<1)
  - 5: saturate(a+b) & c, where sum carry-out forces all-ones
  - 6: ((a&b)+((a^b)>>1)) | c
  - 7: {a[N-2:0],a[N-1]} ^ b ^ c
  - a, b, min and max are unsigned.
  - op_cnt++ per accepted opcode.
  - An accepted op_last=1 moves to DRAIN.
  - An accepted opcode with op_cnt=MAX_OPS-1 and op_last=0 also moves to DRAIN and sets err=1.
  - err holds until the next start or rst.
  - The acc update and the DRAIN entry occur on the same edge. The first out beat reflects the final acc.
- DRAIN:
  - out = acc[beat_cnt*N_width +: N_width] with out_valid=1.
  - out_ready=1 advances beat_cnt.
  - out_ready=0 holds out, beat_cnt and state unchanged.
  - The beat accepted with beat_cnt=BEATS-1 moves to IDLE, asserts done for exactly one cycle (registered, coincident with the first IDLE cycle) and sets beat_cnt=0.
- abort=1 outside IDLE:
  - Next state is IDLE; counters are cleared; no done pulse; err is unchanged.
  - abort takes priority over every handshake on the same cycle.
  - abort in IDLE takes priority over start.
- acc and a_reg/b_reg hold their values in IDLE until the next start; they are visible only through DRAIN.
- No combinational path from inputs to outputs except out_valid/in_ready/op_ready, which decode state only.

Test Plan (N=16, N_width=4, MAX_OPS=4 unless stated):
1. Basic job:
   - Stimulus: start; load a=0x1234, b=0x00F0 as beats (a,b)=(4,0),(3,F),(2,0),(1,0); ops 0 then 1 with op_last; out_ready=1.
   - Response: acc=0x0030 then 0x12F4; out beats 4,F,2,1; done pulses once; state_res sequence 0,1,2,3,0.
2. Saturation and rotate:
   - a=0xFFFF, b=0x0001; ops 4, then 5 with op_last -> acc 0xFFFF, then 0xFFFF.
   - Separate job with a=0x8001, b=0, op 7 with op_last -> out beats 3,0,0,0.
3. Backpressure: job with a=0x0005, b=0x0009, op 2 with op_last (acc=0x0004); hold out_ready=0 for 3 cycles on beat index 2 -> out stays 0 and out_valid stays 1 for those cycles; then completes with beats 4,0,0,0.
4. Handshake gaps: in_valid deasserted between beats and op_valid idle for 5 cycles -> results identical to scenario 1; in_ready/op_ready high only in LOAD/EXEC.
5. Overflow: 4 ops (0,0,0,0), none with op_last -> DRAIN after the 4th; err=1 through DRAIN and IDLE; cleared on next start.
6. Abort/reset:
   - abort after 2 LOAD beats -> IDLE next cycle, no done, busy=0.
   - rst pulse mid-DRAIN -> all outputs 0 immediately (asynchronous), state_res=0.
   - A new job afterwards produces correct results.

Source files
------------

// File: rtl/fsm_stream_alu_if.sv
// ============================================================================
// Module   : fsm_stream_alu_if
// Brief    : Handshake/stream bundle between a host and fsm_stream_alu.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fsm_stream_alu_if #(
    parameter int N_width = 4
);
    logic               start;
    logic               abort;
    logic               in_valid;
    logic               in_ready;
    logic [N_width-1:0] a;
    logic [N_width-1:0] b;
    logic               op_valid;
    logic               op_ready;
    logic [2:0]         op_code;
    logic               op_last;
    logic [N_width-1:0] out;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               done;
    logic               err;
    logic [1:0]         state_res;

    modport master (
        output start, abort, in_valid, a, b, op_valid, op_code, op_last, out_ready,
        input  in_ready, op_ready, out, out_valid, busy, done, err, state_res
    );

    modport slave (
        input  start, abort, in_valid, a, b, op_valid, op_code, op_last, out_ready,
        output in_ready, op_ready, out, out_valid, busy, done, err, state_res
    );
endinterface

`default_nettype wire

// File: rtl/fsm_stream_alu.sv
// ============================================================================
// Module   : fsm_stream_alu
// Brief    : Beat-serial operand loader, opcode-driven accumulator ALU and
//            beat-serial result drain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_stream_alu #(
    parameter int N       = 64,
    parameter int N_width = 4,
    parameter int MAX_OPS = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    fsm_stream_alu_if.slave      bus
);

    localparam int BEATS = N / N_width;
    localparam int BW    = $clog2(BEATS);
    localparam int OW    = $clog2(MAX_OPS + 1);

    localparam logic [1:0]    C_IDLE      = 2'd0;
    localparam logic [1:0]    C_LOAD      = 2'd1;
    localparam logic [1:0]    C_EXEC      = 2'd2;
    localparam logic [1:0]    C_DRAIN     = 2'd3;
    localparam logic [BW-1:0] C_LAST_BEAT = BW'(BEATS - 1);
    localparam logic [OW-1:0] C_LAST_OP   = OW'(MAX_OPS - 1);

    logic [1:0]    r_state;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_acc;
    logic [BW-1:0] r_beat_cnt;
    logic [OW-1:0] r_op_cnt;
    logic          r_done;
    logic          r_err;

    logic [N-1:0]  w_alu;
    logic [N-1:0]  w_min;
    logic [N-1:0]  w_max;
    logic [N-1:0]  w_absdiff;
    logic [N:0]    w_sum;
    logic          w_last_beat;

    assign w_last_beat = (r_beat_cnt == C_LAST_BEAT);
    assign w_min       = (r_a < r_b) ? r_a : r_b;
    assign w_max       = (r_a < r_b) ? r_b : r_a;
    assign w_absdiff   = (r_a < r_b) ? (r_b - r_a) : (r_a - r_b);
    assign w_sum       = {1'b0, r_a} + {1'b0, r_b};

    always_comb begin
        w_alu = '0;
        case (bus.op_code)
            3'd0: w_alu = (r_a & r_b) | r_acc;
            3'd1: w_alu = (r_a ^ r_b) + r_acc;
            3'd2: w_alu = w_absdiff ^ r_acc;
            3'd3: w_alu = {r_acc[N-1:N/2], w_min[N/2-1:0]};
            3'd4: w_alu = w_max + (r_acc << 1);
            // A carry out of the unsigned sum saturates to all-ones before masking.
            3'd5: w_alu = (w_sum[N] ? {N{1'b1}} : w_sum[N-1:0]) & r_acc;
            3'd6: w_alu = ((r_a & r_b) + ((r_a ^ r_b) >> 1)) | r_acc;
            3'd7: w_alu = {r_a[N-2:0], r_a[N-1]} ^ r_b ^ r_acc;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= C_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_beat_cnt <= '0;
            r_op_cnt   <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.abort) begin
                // Abort beats every handshake and start; err deliberately survives.
                r_state    <= C_IDLE;
                r_beat_cnt <= '0;
                r_op_cnt   <= '0;
            end else begin
                case (r_state)
                    C_IDLE: begin
                        if (bus.start) begin
                            r_a        <= '0;
                            r_b        <= '0;
                            r_acc      <= '0;
                            r_beat_cnt <= '0;
                            r_op_cnt   <= '0;
                            r_err      <= 1'b0;
                            r_state    <= C_LOAD;
                        end
                    end
                    C_LOAD: begin
                        if (bus.in_valid) begin
                            r_a[r_beat_cnt*N_width +: N_width] <= bus.a;
                            r_b[r_beat_cnt*N_width +: N_width] <= bus.b;
                            if (w_last_beat) begin
                                r_beat_cnt <= '0;
                                r_state    <= C_EXEC;
                            end else begin
                                r_beat_cnt <= r_beat_cnt + BW'(1);
                            end
                        end
                    end
                    C_EXEC: begin
                        if (bus.op_valid) begin
                            r_acc    <= w_alu;
                            r_op_cnt <= r_op_cnt + OW'(1);
                            if (bus.op_last) begin
                                r_state <= C_DRAIN;
                            end else if (r_op_cnt == C_LAST_OP) begin
                                r_state <= C_DRAIN;
                                r_err   <= 1'b1;
                            end
                        end
                    end
                    C_DRAIN: begin
                        if (bus.out_ready) begin
                            if (w_last_beat) begin
                                r_beat_cnt <= '0;
                                r_state    <= C_IDLE;
                                r_done     <= 1'b1;
                            end else begin
                                r_beat_cnt <= r_beat_cnt + BW'(1);
                            end
                        end
                    end
                    default: r_state <= C_IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready  = (r_state == C_LOAD);
    assign bus.op_ready  = (r_state == C_EXEC);
    assign bus.out_valid = (r_state == C_DRAIN);
    assign bus.out       = (r_state == C_DRAIN) ? r_acc[r_beat_cnt*N_width +: N_width] : '0;
    assign bus.busy      = (r_state != C_IDLE);
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.state_res = r_state;

endmodule

`default_nettype wire
